// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter library. The up and down counters import
// this package so that both use the same default modulus and the same state
// encoding.
//   state_e                : FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_COUNTER_NUMBER : default modulus; legal counts are 0 .. N-1
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int DEFAULT_COUNTER_NUMBER = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : counter_pkg

// File: rtl/counter_down_timer.sv
// -----------------------------------------------------------------------------
// counter_down_timer
// Programmable down-counting timer. It holds a loadable reload value and
// counts down to zero on command. It raises a one-cycle terminal-count strobe
// when the count reaches zero. In one-shot mode it then stops in DONE. In
// periodic mode it reloads itself and keeps running.
//
// Parameters
//   COUNTER_NUMBER : modulus; legal count values are 0 .. COUNTER_NUMBER-1
//   WIDTH          : counter width; 2**WIDTH must be >= COUNTER_NUMBER
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   load_valid  in   request to write load_value into the reload register
//   load_value  in   new reload value (clamped to COUNTER_NUMBER-1)
//   load_ready  out  1 in IDLE/DONE, 0 in RUN (combinational)
//   start       in   begin a countdown from the reload value
//   pause       in   hold the count while running
//   stop        in   abort to IDLE (highest priority)
//   auto_reload in   periodic mode select, sampled at terminal count
//   count_out   out  current count (registered)
//   busy        out  state == RUN
//   done        out  state == DONE
//   tc_pulse    out  registered one-cycle terminal-count strobe
// -----------------------------------------------------------------------------
module counter_down_timer
    import counter_pkg::*;
#(
    parameter int COUNTER_NUMBER = DEFAULT_COUNTER_NUMBER,
    parameter int WIDTH          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse
);

    localparam logic [WIDTH-1:0] MAX_COUNT  = WIDTH'(COUNTER_NUMBER - 1);
    // One bit wider than the load value so that a modulus of exactly
    // 2**WIDTH can be represented in the comparison.
    localparam logic [WIDTH:0]   LOAD_LIMIT = (WIDTH + 1)'(COUNTER_NUMBER);
    localparam logic [WIDTH-1:0] ZERO_COUNT = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_COUNT  = WIDTH'(1);

    // Out-of-range reload requests saturate at the largest legal count.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] result;
        if ({1'b0, value} >= LOAD_LIMIT) begin
            result = MAX_COUNT;
        end else begin
            result = value;
        end
        return result;
    endfunction

    state_e           state_r;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] reload_r;
    logic             tc_r;

    logic             load_ready_s;
    logic             load_accept_s;
    logic [WIDTH-1:0] load_clamped_s;
    logic [WIDTH-1:0] start_value_s;

    // Load handshake: the reload register is writable only while not running.
    always_comb begin
        load_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: load_ready_s = 1'b1;
            ST_DONE: load_ready_s = 1'b1;
            ST_RUN:  load_ready_s = 1'b0;
            default: load_ready_s = 1'b0;
        endcase
    end

    // A load that coincides with start takes effect for that very start.
    always_comb begin
        load_accept_s  = load_valid & load_ready_s;
        load_clamped_s = clamp_load(load_value);
        start_value_s  = reload_r;
        if (load_accept_s) begin
            start_value_s = load_clamped_s;
        end else begin
            start_value_s = reload_r;
        end
    end

    // Reload register. stop does not block a load, because load_ready alone
    // qualifies the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_r <= MAX_COUNT;
        end else if (load_accept_s) begin
            reload_r <= load_clamped_s;
        end else begin
            reload_r <= reload_r;
        end
    end

    // Timer FSM with its count and terminal-count strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            count_r <= ZERO_COUNT;
            tc_r    <= 1'b0;
        end else begin
            tc_r <= 1'b0;
            if (stop) begin
                // stop wins over start, pause and terminal count.
                state_r <= ST_IDLE;
                count_r <= ZERO_COUNT;
            end else begin
                case (state_r)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state_r <= ST_RUN;
                            count_r <= start_value_s;
                        end else begin
                            state_r <= state_r;
                            count_r <= count_r;
                        end
                    end
                    ST_RUN: begin
                        if (pause) begin
                            // A paused zero does not fire.
                            count_r <= count_r;
                        end else if (count_r != ZERO_COUNT) begin
                            count_r <= count_r - ONE_COUNT;
                        end else begin
                            tc_r <= 1'b1;
                            if (auto_reload) begin
                                count_r <= reload_r;
                            end else begin
                                state_r <= ST_DONE;
                                count_r <= ZERO_COUNT;
                            end
                        end
                    end
                    default: begin
                        // Unreachable encoding: fall back to a safe idle.
                        state_r <= ST_IDLE;
                        count_r <= ZERO_COUNT;
                    end
                endcase
            end
        end
    end

    assign load_ready = load_ready_s;
    assign count_out  = count_r;
    assign tc_pulse   = tc_r;
    assign busy       = (state_r == ST_RUN);
    assign done       = (state_r == ST_DONE);

endmodule : counter_down_timer

// File: doc/counter_down_timer.md
# counter_down_timer

Programmable down-counting timer; the countdown counterpart of the free-running up counter in the counter library. It holds a loadable reload value, counts down to zero on command, and flags terminal count. It stops at zero in one-shot mode or reloads itself in periodic mode. It sits beside the up counter as the timeout and tick generator for control FSMs.

## Interface
- COUNTER_NUMBER, 16: modulus. Legal count values are 0 .. COUNTER_NUMBER-1.
- WIDTH, 4: counter width; must satisfy 2^WIDTH >= COUNTER_NUMBER.
- clk  in  1: rising-edge clock.
- rst  in  1: reset. One clock; reset is asynchronous and active-high.
- load_valid  in  1: request to write load_value into the reload register.
- load_value  in  WIDTH: new reload value.
- load_ready  out  1: combinational; 1 in IDLE and DONE, 0 in RUN.
- start  in  1: begin a countdown from the reload register.
- pause  in  1: hold the count while in RUN.
- stop  in  1: abort to IDLE.
- auto_reload  in  1: periodic mode select.
- count_out  out  WIDTH: current count (registered).
- busy  out  1: state == RUN.
- done  out  1: state == DONE.
- tc_pulse  out  1: registered one-cycle terminal-count strobe.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, count_out=0, reload_reg=COUNTER_NUMBER-1, tc_pulse=0.
- Reload write:
  - Occurs when load_valid && load_ready.
  - load_value >= COUNTER_NUMBER clamps to COUNTER_NUMBER-1.
  - In RUN, load_valid is ignored and no write occurs.
- IDLE/DONE with start=1:
  - count_out <= reload value; state <= RUN.
  - If a load is accepted in the same cycle, the new (clamped) load_value is used, not the old reload_reg.
- RUN, pause=1: count_out holds; state stays RUN; tc_pulse=0.
- RUN, pause=0, count_out != 0: count_out <= count_out - 1.
- RUN, pause=0, count_out == 0:
  - tc_pulse <= 1 for exactly one cycle.
  - auto_reload=1 (sampled this cycle): count_out <= reload_reg; stay RUN.
  - auto_reload=0: state <= DONE; count_out stays 0.
- stop (any state): state <= IDLE; count_out <= 0; tc_pulse <= 0.
  - stop has priority over start, pause and terminal count.
  - stop coincident with a terminal count produces no tc_pulse.
- start while in RUN is ignored. Restart requires stop, then start.
- pause has priority over terminal count: a paused zero does not fire.
- Reload value 0:
  - One-shot fires on the cycle after start.
  - Periodic mode gives tc_pulse every cycle.
- DONE: count_out=0, done=1. Remains until start or stop.
- Arithmetic is WIDTH bits unsigned. Decrement never executes at 0, so there is no underflow wrap.

## Timing
- start sampled at edge N, reload value R:
  - count_out=R after edge N.
  - count_out=0 after edge N+R.
  - tc_pulse=1 and done=1 (one-shot) after edge N+R+1.
- Each paused cycle extends these times by one.
- Periodic period is R+1 cycles between tc_pulse assertions. A pause stretches the current period only.
- Reset assertion is asynchronous and immediate. Deassertion is synchronous to clk by the system reset synchroniser.
- Reset mid-count discards reload_reg, which returns to COUNTER_NUMBER-1.

## Structure
- Shared package counter_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the COUNTER_NUMBER default, so up and down counters agree on modulus.
- Single module. A separate sub-module is not warranted; the reload register, clamp and FSM are local.

## Test plan
- Reset then start with no load: count_out 15,14,...,0, then tc_pulse one cycle 16 cycles after start; done=1; count_out holds 0.
- Load 5 with auto_reload=1, start: tc_pulse every 6 cycles for at least 3 periods; busy stays 1.
- Load 3, start, pause for 4 cycles when count_out=2: count_out holds 2; tc_pulse arrives 4 cycles late; no early pulse.
- Load 20 (clamps to 15), then load_valid during RUN with value 2: reload_reg stays 15; load_ready=0 throughout RUN.
- stop on the exact cycle count_out=0 in RUN: IDLE, count_out=0, tc_pulse never asserted. Load 0 then start: tc_pulse on the cycle after start.
- Assert rst mid-count at count_out=7: outputs clear immediately (count_out=0, busy=0). A later start counts from 15.
